// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the stream_demux slice.
// Out-of-range drop behaviour is selected by STREAM_DEMUX_DROP_EN (see stream_demux.sv).
package stream_demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_CH   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  // Select width for a channel count; never narrower than one bit.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel.
// Can take a new beat while its current beat drains, so a ready consumer sees no bubbles.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_last_i,
  input  logic              rd_ready_i,
  output logic              can_accept_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W:0]   beat_q, beat_d;

  assign can_accept_o = !valid_q || rd_ready_i;

  // A write wins over a drain, which makes drain+fill a straight replacement.
  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (wr_en_i) begin
      valid_d = 1'b1;
      beat_d  = {wr_last_i, wr_data_i};
    end else if (rd_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = beat_q[DATA_W-1:0];
  assign last_o  = beat_q[DATA_W];

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-packet select locking.
// Define STREAM_DEMUX_DROP_EN to swallow packets addressed past N_CH instead of stalling them.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH,
  parameter int SEL_W  = sel_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      din,
  input  logic [SEL_W-1:0]       din_sel,
  input  logic                   din_last,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [N_CH*DATA_W-1:0] dout,
  output logic [N_CH-1:0]        dout_last,
  output logic [N_CH-1:0]        dout_valid,
  input  logic [N_CH-1:0]        dout_ready,
  output logic                   busy
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] locked_sel_q, locked_sel_d;
  logic [SEL_W-1:0] eff_sel;
  logic [N_CH-1:0]  slot_can;
  logic [N_CH-1:0]  slot_wr;
  logic             sel_in_range;
  logic             sel_can;
  logic             accept;

  assign eff_sel = (state_q == IDLE) ? din_sel : locked_sel_q;

  // Decode by comparison so a select past N_CH simply matches no slot.
  always_comb begin
    sel_in_range = 1'b0;
    sel_can      = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (eff_sel == SEL_W'(k)) begin
        sel_in_range = 1'b1;
        sel_can      = slot_can[k];
      end
    end
  end

`ifdef STREAM_DEMUX_DROP_EN
  assign din_ready = sel_in_range ? sel_can : 1'b1;
`else
  assign din_ready = sel_in_range & sel_can;
`endif

  assign accept = din_valid & din_ready;

  always_comb begin
    slot_wr = '0;
    for (int k = 0; k < N_CH; k++) begin
      slot_wr[k] = accept && (eff_sel == SEL_W'(k));
    end
  end

  always_comb begin
    state_d      = state_q;
    locked_sel_d = locked_sel_q;
    case (state_q)
      IDLE: begin
        if (accept && !din_last) begin
          state_d      = PKT;
          locked_sel_d = din_sel;
        end
      end
      PKT: begin
        if (accept && din_last) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      locked_sel_q <= '0;
    end else begin
      state_q      <= state_d;
      locked_sel_q <= locked_sel_d;
    end
  end

  assign busy = (state_q == PKT);

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (slot_wr[k]),
      .wr_data_i   (din),
      .wr_last_i   (din_last),
      .rd_ready_i  (dout_ready[k]),
      .can_accept_o(slot_can[k]),
      .valid_o     (dout_valid[k]),
      .data_o      (dout[k*DATA_W +: DATA_W]),
      .last_o      (dout_last[k])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: table vectors, hand-written corner sequences and
// randomized traffic compared against a per-channel queue model.
module tb_stream_demux;

  localparam int DW  = 8;
  localparam int NC  = 8;
  localparam int NC6 = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0]    din;
  logic [2:0]       din_sel;
  logic             din_last;
  logic             din_valid;
  logic             din_ready;
  logic [NC*DW-1:0] dout;
  logic [NC-1:0]    dout_last;
  logic [NC-1:0]    dout_valid;
  logic [NC-1:0]    dout_ready;
  logic             busy;

  logic [DW-1:0]     d6Din;
  logic [2:0]        d6Sel;
  logic              d6Last;
  logic              d6Valid;
  logic              d6Ready;
  logic [NC6*DW-1:0] d6Dout;
  logic [NC6-1:0]    d6DoutLast;
  logic [NC6-1:0]    d6DoutValid;
  logic [NC6-1:0]    d6DoutReady;
  logic              d6Busy;

  stream_demux #(.DATA_W(DW), .N_CH(NC)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_sel(din_sel), .din_last(din_last),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  stream_demux #(.DATA_W(DW), .N_CH(NC6)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(d6Din), .din_sel(d6Sel), .din_last(d6Last),
    .din_valid(d6Valid), .din_ready(d6Ready), .dout(d6Dout), .dout_last(d6DoutLast),
    .dout_valid(d6DoutValid), .dout_ready(d6DoutReady), .busy(d6Busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a queue of {last, data}; a packet is open or not.
  logic [DW:0] chq[NC][$];
  logic        mOpen;
  logic [2:0]  mSel;
  logic        lastAcc;

  typedef struct {
    logic [2:0]    sel;
    logic [DW-1:0] data;
    logic [NC-1:0] expValid;
  } vec_t;
  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NC; k++) chq[k].delete();
    mOpen   = 1'b0;
    mSel    = '0;
    lastAcc = 1'b0;
  endtask

  function automatic logic modelReady();
    int t;
    t = mOpen ? int'(mSel) : int'(din_sel);
    return (chq[t].size() == 0) || dout_ready[t];
  endfunction

  task automatic checkModel();
    logic [NC-1:0]    ev;
    logic [NC-1:0]    el;
    logic [NC*DW-1:0] ed;
    logic [NC*DW-1:0] mask;
    logic [DW:0]      b;
    ev = '0; el = '0; ed = '0; mask = '0;
    for (int k = 0; k < NC; k++) begin
      if (chq[k].size() > 0) begin
        b = chq[k][0];
        ev[k] = 1'b1;
        el[k] = b[DW];
        ed[k*DW +: DW]   = b[DW-1:0];
        mask[k*DW +: DW] = '1;
      end
    end
    checkOutput("din_ready", din_ready, modelReady());
    checkOutput("busy", busy, mOpen);
    checkOutput("dout_valid", dout_valid, ev);
    checkOutput("dout_data", dout & mask, ed);
    checkOutput("dout_last", dout_last & ev, el);
  endtask

  task automatic modelAdvance();
    logic acc;
    int   t;
    if (!rst_n) begin
      modelReset();
      return;
    end
    t   = mOpen ? int'(mSel) : int'(din_sel);
    acc = din_valid && modelReady();
    for (int k = 0; k < NC; k++) begin
      if (chq[k].size() > 0 && dout_ready[k]) void'(chq[k].pop_front());
    end
    if (acc) begin
      chq[t].push_back({din_last, din});
      if (!mOpen && !din_last) begin
        mOpen = 1'b1;
        mSel  = din_sel;
      end else if (mOpen && din_last) begin
        mOpen = 1'b0;
      end
    end
    lastAcc = acc;
  endtask

  task automatic tick();
    @(negedge clk);
    checkModel();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [DW-1:0] data, input logic last,
                               input int maxCycles, input string name);
    din_valid = 1'b1;
    din_sel   = sel;
    din       = data;
    din_last  = last;
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      if (lastAcc) break;
    end
    checks++;
    if (!lastAcc) begin
      errors++;
      $display("[TB] FAIL %s beat not accepted within %0d cycles", name, maxCycles);
    end
    din_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{3'd3, 8'hA5, 8'h08};
    vecs[1] = '{3'd0, 8'h3C, 8'h01};
    vecs[2] = '{3'd7, 8'hFF, 8'h80};
    vecs[3] = '{3'd5, 8'h00, 8'h20};
    vecs[4] = '{3'd1, 8'h81, 8'h02};

    rst_n = 1'b0;
    din = '0; din_sel = '0; din_last = 1'b0; din_valid = 1'b0; dout_ready = '1;
    d6Din = '0; d6Sel = '0; d6Last = 1'b0; d6Valid = 1'b0; d6DoutReady = '1;
    modelReset();

    #2;
    checkOutput("rst_valid", dout_valid, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_last", dout_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid6", d6DoutValid, 0);
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] single-beat table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].data, 1'b1, 4, "t1_accept");
      checkOutput("t1_valid", dout_valid, vecs[i].expValid);
      checkOutput("t1_data", dout[int'(vecs[i].sel)*DW +: DW], vecs[i].data);
      checkOutput("t1_last", dout_last[vecs[i].sel], 1);
    end
    tick();

    $display("[TB] select lock across a 4-beat packet");
    checkOutput("t2_busy_pre", busy, 0);
    applyStimulus(3'd5, 8'h11, 1'b0, 4, "t2_b1");
    checkOutput("t2_busy1", busy, 1);
    applyStimulus(3'd2, 8'h22, 1'b0, 4, "t2_b2");
    checkOutput("t2_valid2", dout_valid, 8'h20);
    checkOutput("t2_data2", dout[47:40], 8'h22);
    applyStimulus(3'd2, 8'h33, 1'b0, 4, "t2_b3");
    checkOutput("t2_busy3", busy, 1);
    applyStimulus(3'd2, 8'h44, 1'b1, 4, "t2_b4");
    checkOutput("t2_busy4", busy, 0);
    checkOutput("t2_data4", dout[47:40], 8'h44);
    checkOutput("t2_last4", dout_last[5], 1);
    tick();

    $display("[TB] stalled channel holds input order");
    dout_ready = 8'hFD;
    applyStimulus(3'd1, 8'hA1, 1'b0, 4, "t3_b1");
    din_valid = 1'b1; din_sel = 3'd1; din = 8'hA2; din_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3_stall_ready", din_ready, 0);
      checkOutput("t3_hold_data", dout[15:8], 8'hA1);
    end
    dout_ready = '1;
    applyStimulus(3'd1, 8'hA2, 1'b1, 2, "t3_b2");
    checkOutput("t3_valid2", dout_valid, 8'h02);
    checkOutput("t3_data2", dout[15:8], 8'hA2);
    applyStimulus(3'd6, 8'hB6, 1'b1, 2, "t3_ch6");
    checkOutput("t3_valid6", dout_valid, 8'h40);
    checkOutput("t3_data6", dout[55:48], 8'hB6);
    tick();

    $display("[TB] 16-beat burst");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'd0, 8'(8'h40 + i), (i == 15), 1, "t4_nobubble");
      checkOutput("t4_valid", dout_valid[0], 1);
      checkOutput("t4_data", dout[7:0], 8'(8'h40 + i));
    end
    tick();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      din_valid  = 1'($urandom_range(0, 1));
      din_sel    = 3'($urandom_range(0, 7));
      din_last   = ($urandom_range(0, 3) == 0);
      din        = 8'($urandom);
      dout_ready = 8'($urandom);
      tick();
    end
    dout_ready = '1;
    applyStimulus(3'd0, 8'h00, 1'b1, 4, "rand_close");
    tick();
    tick();

    $display("[TB] out-of-range select, N_CH=6");
    d6Valid = 1'b1; d6Sel = 3'd7; d6Din = 8'h77; d6Last = 1'b0;
`ifdef STREAM_DEMUX_DROP_EN
    #1;
    checkOutput("t5_drop_ready1", d6Ready, 1);
    tick();
    checkOutput("t5_drop_busy1", d6Busy, 1);
    checkOutput("t5_drop_valid1", d6DoutValid, 0);
    d6Din = 8'h78; d6Last = 1'b1;
    #1;
    checkOutput("t5_drop_ready2", d6Ready, 1);
    tick();
    checkOutput("t5_drop_busy2", d6Busy, 0);
    checkOutput("t5_drop_valid2", d6DoutValid, 0);
    d6Sel = 3'd4; d6Din = 8'h79; d6Last = 1'b1;
    tick();
    checkOutput("t5_after_valid", d6DoutValid, 6'b010000);
    checkOutput("t5_after_data", d6Dout[39:32], 8'h79);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t5_stall_ready", d6Ready, 0);
      checkOutput("t5_stall_busy", d6Busy, 0);
      checkOutput("t5_stall_valid", d6DoutValid, 0);
    end
    d6Sel = 3'd4;
    #1;
    checkOutput("t5_route_ready", d6Ready, 1);
    tick();
    checkOutput("t5_route_valid", d6DoutValid, 6'b010000);
    checkOutput("t5_route_data", d6Dout[39:32], 8'h77);
    checkOutput("t5_route_busy", d6Busy, 1);
    d6Sel = 3'd7; d6Din = 8'h78; d6Last = 1'b1;
    tick();
    checkOutput("t5_lock_valid", d6DoutValid, 6'b010000);
    checkOutput("t5_lock_data", d6Dout[39:32], 8'h78);
    checkOutput("t5_lock_busy", d6Busy, 0);
`endif
    d6Valid = 1'b0;
    tick();

    $display("[TB] reset mid-packet");
    dout_ready = 8'hFB;
    applyStimulus(3'd2, 8'hC2, 1'b0, 4, "t6_b1");
    checkOutput("t6_full", dout_valid, 8'h04);
    checkOutput("t6_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_rst_valid", dout_valid, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_dout", dout, 0);
    tick();
    rst_n = 1'b1;
    dout_ready = '1;
    applyStimulus(3'd4, 8'hD4, 1'b1, 2, "t6_fresh");
    checkOutput("t6_fresh_valid", dout_valid, 8'h10);
    checkOutput("t6_fresh_data", dout[39:32], 8'hD4);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
